// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch has absolute priority, the CPU uses free cycles.
// Each read is tagged at issue so the returning word is steered to the pixel or the CPU.
module vga_fb_arbiter #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] BLANK_PIX = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        vid_x,
  input  logic [3:0]        vid_y,
  input  logic              vid_blank,
  output logic [DATA_W-1:0] pix_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [8:0]        cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [8:0]        ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    CPU_BUSY = 2'd1,
    CPU_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  vid_pos;
  logic [8:0]  last_pos_q;
  logic        blank_q;
  logic        disp_pend;
  logic        cpu_grant;
  logic        rd_vld_p0, rd_vld_p1;
  logic        rd_cpu_p0, rd_cpu_p1;

  assign vid_pos = {vid_y, vid_x};

  always_comb begin
    disp_pend = !vid_blank && ((vid_pos != last_pos_q) || blank_q);
  end

  // cpu_ack is registered and trails CPU_ACK by one cycle; holding off a grant
  // while it is high keeps a requester that drops req on ack from being served twice.
  always_comb begin
    state_d   = state_q;
    cpu_grant = 1'b0;
    case (state_q)
      ARB: begin
        if (!disp_pend && cpu_req && !cpu_ack) begin
          cpu_grant = 1'b1;
          state_d   = CPU_BUSY;
        end
      end
      CPU_BUSY: state_d = CPU_ACK;
      CPU_ACK:  state_d = ARB;
      default:  state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      last_pos_q <= vid_pos;
      blank_q    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rd_vld_p0  <= 1'b0;
      rd_cpu_p0  <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_cpu_p1  <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      pix_data   <= BLANK_PIX;
    end else begin
      state_q    <= state_d;
      last_pos_q <= vid_pos;
      blank_q    <= vid_blank;

      // p0: RAM command issue, one op per cycle, display first
      if (disp_pend) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b0;
        ram_addr  <= vid_pos;
        rd_vld_p0 <= 1'b1;
        rd_cpu_p0 <= 1'b0;
      end else if (cpu_grant) begin
        ram_en    <= 1'b1;
        ram_we    <= cpu_we;
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        rd_vld_p0 <= !cpu_we;
        rd_cpu_p0 <= 1'b1;
      end else begin
        ram_en    <= 1'b0;
        ram_we    <= 1'b0;
        rd_vld_p0 <= 1'b0;
      end

      // p1: read data present on ram_rdata, steer by tag
      rd_vld_p1 <= rd_vld_p0;
      rd_cpu_p1 <= rd_cpu_p0;

      if (rd_vld_p1 && rd_cpu_p1) begin
        cpu_rdata <= ram_rdata;
      end
      cpu_ack <= (state_q == CPU_ACK);

      if (vid_blank) begin
        pix_data <= BLANK_PIX;
      end else if (rd_vld_p1 && !rd_cpu_p1) begin
        pix_data <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural RAM, directed vector table and sequences,
// then randomized display/CPU traffic checked against a cycle-history model.
module tb_vga_fb_arbiter;

  localparam logic [7:0] BLK = 8'hE1;
  localparam int         NR  = 2000;

  logic       clk, rst, ld;
  logic [4:0] vid_x;
  logic [3:0] vid_y;
  logic       vid_blank;
  logic [7:0] pix_data;
  logic       cpu_req, cpu_we, cpu_ack;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       ram_en, ram_we;
  logic [8:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] mem    [0:511];
  logic [7:0] shadow [0:511];
  logic [8:0] hpos   [0:NR-1];
  logic       hb     [0:NR-1];

  vga_fb_arbiter #(.DATA_W(8), .BLANK_PIX(BLK)) dut (
    .clk(clk), .rst(rst),
    .vid_x(vid_x), .vid_y(vid_y), .vid_blank(vid_blank),
    .pix_data(pix_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [8:0] a);
    logic [15:0] v;
    if (a == 9'h065) return 8'hA5;
    v = 16'(a) * 16'd7 + 16'd3;
    return v[7:0];
  endfunction

  // single-port synchronous RAM: read data valid the cycle after the command
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(9'(i));
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // display demand in cycle t, straight from the rule: visible, and moved or leaving blank
  function automatic logic dem(input int t);
    return !hb[t] && ((hpos[t] != hpos[t-1]) || hb[t-1]);
  endfunction

  task automatic cpu_op(input logic we, input logic [8:0] a, input logic [7:0] d,
                        output int op_cyc, output int ack_cyc, output logic [7:0] rd);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    op_cyc = -1; ack_cyc = -1; rd = 8'h00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (op_cyc < 0 && ram_en && ram_we == we && ram_addr == a && (!we || ram_wdata == d))
        op_cyc = i;
      if (cpu_ack) begin
        ack_cyc = i;
        rd = cpu_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic [3:0] y;
    logic [4:0] x;
    logic       b;
    logic       en;
    logic [8:0] addr;
    logic [7:0] pix;
  } vec_t;

  vec_t tbl [0:12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         op_c, ack_c, nack;
    logic [7:0] rd;
    logic       en_s [10];
    logic       we_s [10];
    logic       ack_s[10];
    logic [8:0] addr_s[10];
    logic [7:0] pix_s[10];
    logic [7:0] rd_s [10];
    logic       busy, drop, bl, cur_we;
    logic [8:0] cur_addr;
    logic [7:0] cur_data, pm;
    int         wait_c;

    tbl[0]  = '{4'd3, 5'd5, 1'b0, 1'b0, 9'h000, pat(9'h064)};
    tbl[1]  = '{4'd3, 5'd5, 1'b0, 1'b1, 9'h065, pat(9'h064)};
    tbl[2]  = '{4'd3, 5'd5, 1'b0, 1'b0, 9'h000, pat(9'h064)};
    tbl[3]  = '{4'd3, 5'd5, 1'b0, 1'b0, 9'h000, 8'hA5};
    tbl[4]  = '{4'd3, 5'd6, 1'b0, 1'b0, 9'h000, 8'hA5};
    tbl[5]  = '{4'd3, 5'd7, 1'b0, 1'b1, 9'h066, 8'hA5};
    tbl[6]  = '{4'd3, 5'd7, 1'b1, 1'b1, 9'h067, 8'hA5};
    tbl[7]  = '{4'd3, 5'd7, 1'b1, 1'b0, 9'h000, BLK};
    tbl[8]  = '{4'd3, 5'd7, 1'b1, 1'b0, 9'h000, BLK};
    tbl[9]  = '{4'd3, 5'd8, 1'b0, 1'b0, 9'h000, BLK};
    tbl[10] = '{4'd3, 5'd8, 1'b0, 1'b1, 9'h068, BLK};
    tbl[11] = '{4'd3, 5'd8, 1'b0, 1'b0, 9'h000, BLK};
    tbl[12] = '{4'd3, 5'd8, 1'b0, 1'b0, 9'h000, pat(9'h068)};

    for (int i = 0; i < 512; i++) shadow[i] = pat(9'(i));

    rst = 1'b1; ld = 1'b1;
    vid_x = 5'd4; vid_y = 4'd3; vid_blank = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 9'h000; cpu_wdata = 8'h00;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix",   32'(pix_data),  32'(BLK));
    chk("rst_ack",   32'(cpu_ack),   32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_en",    32'(ram_en),    32'd0);
    chk("rst_we",    32'(ram_we),    32'd0);
    chk("rst_addr",  32'(ram_addr),  32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    rst = 1'b0; ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_idle_en", 32'(ram_en), 32'd0);
    end

    // blank pulse so the pixel register settles on a known word at (3,4)
    @(posedge clk); #1 vid_blank = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 vid_blank = 1'b0;
    repeat (3) @(posedge clk);

    // display latency and blank entry/exit vectors
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      vid_y = tbl[k].y; vid_x = tbl[k].x; vid_blank = tbl[k].b;
      @(negedge clk);
      chk($sformatf("vec%0d_en", k), 32'(ram_en), 32'(tbl[k].en));
      if (tbl[k].en) begin
        chk($sformatf("vec%0d_addr", k), 32'(ram_addr), 32'(tbl[k].addr));
        chk($sformatf("vec%0d_we", k),   32'(ram_we),   32'd0);
      end
      chk($sformatf("vec%0d_pix", k), 32'(pix_data), 32'(tbl[k].pix));
    end

    // CPU write then read during blank
    @(posedge clk); #1 vid_blank = 1'b1;
    repeat (2) @(posedge clk);
    cpu_op(1'b1, 9'h1FF, 8'h3C, op_c, ack_c, rd);
    chk("cpu_wr_issue", 32'(op_c), 32'd1);
    chk("cpu_wr_ack",   32'(ack_c - op_c), 32'd2);
    shadow[9'h1FF] = 8'h3C;
    cpu_op(1'b0, 9'h1FF, 8'h00, op_c, ack_c, rd);
    chk("cpu_rd_issue", 32'(op_c), 32'd1);
    chk("cpu_rd_ack",   32'(ack_c), 32'd3);
    chk("cpu_rd_data",  32'(rd), 32'h3C);
    chk("blank_pix",    32'(pix_data), 32'(BLK));

    // display and CPU request in the same cycle
    @(posedge clk); #1 vid_blank = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vid_x = 5'd9;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1FF;
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_s[i] = ram_en; we_s[i] = ram_we; addr_s[i] = ram_addr;
      pix_s[i] = pix_data; ack_s[i] = cpu_ack; rd_s[i] = cpu_rdata;
      if (cpu_ack) begin
        nack++;
        @(posedge clk); #1 cpu_req = 1'b0;
      end
    end
    chk("cfl_disp_en",   32'(en_s[1]),   32'd1);
    chk("cfl_disp_we",   32'(we_s[1]),   32'd0);
    chk("cfl_disp_addr", 32'(addr_s[1]), 32'h069);
    chk("cfl_cpu_en",    32'(en_s[2]),   32'd1);
    chk("cfl_cpu_we",    32'(we_s[2]),   32'd0);
    chk("cfl_cpu_addr",  32'(addr_s[2]), 32'h1FF);
    chk("cfl_pix",       32'(pix_s[3]),  32'(pat(9'h069)));
    chk("cfl_no_early_ack", 32'(ack_s[3]), 32'd0);
    chk("cfl_ack",       32'(ack_s[4]),  32'd1);
    chk("cfl_rdata",     32'(rd_s[4]),   32'h3C);
    chk("cfl_ack_count", 32'(nack),      32'd1);

    // reset while the CPU op is on the RAM bus
    @(posedge clk); #1 vid_blank = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h1F0; cpu_wdata = 8'h55;
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("rstop_issued", 32'(ram_en & ram_we), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack) nack++;
    end
    chk("rstop_no_ack", 32'(nack), 32'd0);
    cpu_op(1'b1, 9'h1F0, 8'h55, op_c, ack_c, rd);
    chk("rstop_wr_issue", 32'(op_c),  32'd1);
    chk("rstop_wr_ack",   32'(ack_c), 32'd3);
    shadow[9'h1F0] = 8'h55;
    cpu_op(1'b0, 9'h1F0, 8'h00, op_c, ack_c, rd);
    chk("rstop_rd_data",  32'(rd), 32'h55);

    // randomized traffic: display rows 0-7, CPU writes rows 8-15, reads anywhere
    busy = 1'b0; drop = 1'b0; bl = 1'b1; pm = BLK; wait_c = 0;
    cur_we = 1'b0; cur_addr = 9'h000; cur_data = 8'h00;
    for (int t = 0; t < NR; t++) begin
      @(posedge clk); #1;
      if (t >= 4 && $urandom_range(0, 24) == 0) bl = !bl;
      vid_blank = (t < 4) ? 1'b1 : bl;
      if ($urandom_range(0, 1) == 1) vid_x = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) vid_y = 4'($urandom_range(0, 7));
      if (drop) begin
        cpu_req = 1'b0;
        drop = 1'b0;
      end else if (!busy && t >= 4 && $urandom_range(0, 3) == 0) begin
        cur_we = 1'($urandom_range(0, 1));
        if (cur_we) cur_addr = {1'b1, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
        else        cur_addr = 9'($urandom_range(0, 511));
        cur_data = 8'($urandom);
        cpu_req = 1'b1; cpu_we = cur_we; cpu_addr = cur_addr; cpu_wdata = cur_data;
        busy = 1'b1; wait_c = 0;
      end
      @(negedge clk);
      hpos[t] = {vid_y, vid_x};
      hb[t]   = vid_blank;
      if (t >= 4) begin
        pm = hb[t-1] ? BLK : (dem(t-3) ? shadow[hpos[t-3]] : pm);
        chk("rnd_pix", 32'(pix_data), 32'(pm));
        if (dem(t-1)) begin
          chk("rnd_disp_en",   32'(ram_en),   32'd1);
          chk("rnd_disp_we",   32'(ram_we),   32'd0);
          chk("rnd_disp_addr", 32'(ram_addr), 32'(hpos[t-1]));
        end else if (busy && ram_en) begin
          chk("rnd_cpu_addr", 32'(ram_addr), 32'(cur_addr));
          chk("rnd_cpu_we",   32'(ram_we),   32'(cur_we));
          if (cur_we) chk("rnd_cpu_wdata", 32'(ram_wdata), 32'(cur_data));
        end else begin
          chk("rnd_idle_en", 32'(ram_en), 32'd0);
        end
      end
      if (busy) begin
        if (cpu_ack) begin
          if (!cur_we) chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(shadow[cur_addr]));
          else         shadow[cur_addr] = cur_data;
          busy = 1'b0;
          drop = 1'b1;
        end else begin
          wait_c++;
          if (wait_c > 400) begin
            ntests++;
            nfail++;
            $display("FAIL rnd_timeout: no cpu_ack after %0d cycles, required within 400", wait_c);
            busy = 1'b0;
            drop = 1'b1;
          end
        end
      end else begin
        chk("rnd_no_ack", 32'(cpu_ack), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
